regfile_multiport: RTL and testbench

//  Parametrised successor to the fixed 4x8 ABCD register block: NUM_REGS x DATA_WIDTH computational

---
 rtl/regfile_multiport_if.sv | 35 +++
 rtl/regfile_multiport.sv | 86 ++++++++
 tb/tb_regfile_multiport.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_if.sv
// Register file access bundle: write port, two read selects, context ops and read-back.
interface regfile_multiport_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
);
   logic                  run;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [ADDR_WIDTH-1:0] rd_addr_a;
   logic [ADDR_WIDTH-1:0] rd_addr_b;
   logic                  clear;
   logic                  snap_save;
   logic                  snap_restore;
   logic [DATA_WIDTH-1:0] rd_data_a;
   logic [DATA_WIDTH-1:0] rd_data_b;
   logic                  rd_valid;
   logic                  snap_valid;

   modport master (
      output run, wr_en, wr_addr, wr_data,
      output rd_addr_a, rd_addr_b,
      output clear, snap_save, snap_restore,
      input  rd_data_a, rd_data_b,
      input  rd_valid, snap_valid
   );

   modport slave (
      input  run, wr_en, wr_addr, wr_data,
      input  rd_addr_a, rd_addr_b,
      input  clear, snap_save, snap_restore,
      output rd_data_a, rd_data_b,
      output rd_valid, snap_valid
   );
endinterface

// File: rtl/regfile_multiport.sv
// Multiport register file: two registered read ports, one write port,
// optional write-first bypass and a single-cycle shadow save/restore.
module regfile_multiport #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REGS   = 4,
   parameter int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   parameter bit BYPASS     = 1'b1,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input logic                clock,
   input logic                reset_n,
   regfile_multiport_if.slave bus
);
   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t mem_q [NUM_REGS];
   word_t mem_d [NUM_REGS];
   word_t shd_q [NUM_REGS];
   word_t shd_d [NUM_REGS];
   word_t rd_a_q, rd_a_d;
   word_t rd_b_q, rd_b_d;
   logic  rd_valid_q, rd_valid_d;
   logic  snap_valid_q, snap_valid_d;

   always_comb begin
      mem_d        = mem_q;
      shd_d        = shd_q;
      rd_a_d       = rd_a_q;
      rd_b_d       = rd_b_q;
      rd_valid_d   = 1'b0;
      snap_valid_d = snap_valid_q;
      if (bus.run) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.clear) begin
               mem_d[i] = '0;
            end else if (bus.snap_restore) begin
               mem_d[i] = shd_q[i];
            end else if (bus.wr_en &&
                         bus.wr_addr == ADDR_WIDTH'(i)) begin
               mem_d[i] = bus.wr_data;
            end
         end
         // Save always captures the pre-edge file, so save+restore swaps.
         if (bus.snap_save) begin
            shd_d        = mem_q;
            snap_valid_d = 1'b1;
         end
         rd_a_d = '0;
         rd_b_d = '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr_a == ADDR_WIDTH'(i)) begin
               rd_a_d = BYPASS ? mem_d[i] : mem_q[i];
            end
            if (bus.rd_addr_b == ADDR_WIDTH'(i)) begin
               rd_b_d = BYPASS ? mem_d[i] : mem_q[i];
            end
         end
         rd_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= RESET_VALUE;
            shd_q[i] <= RESET_VALUE;
         end
         rd_a_q       <= '0;
         rd_b_q       <= '0;
         rd_valid_q   <= 1'b0;
         snap_valid_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         shd_q        <= shd_d;
         rd_a_q       <= rd_a_d;
         rd_b_q       <= rd_b_d;
         rd_valid_q   <= rd_valid_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   assign bus.rd_data_a  = rd_a_q;
   assign bus.rd_data_b  = rd_b_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.snap_valid = snap_valid_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench: 4-reg write-first file and 5-reg read-first file driven in lockstep,
// checked against a vector table and an array-based reference model.
module tb_regfile_multiport;
   logic       clock;
   logic       rst_n;
   logic       run, wr, clr, sav, rest;
   logic [2:0] wa, ra, rb;
   logic [7:0] wd;

   int vectors;
   int miscompares;

   regfile_multiport_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) if0 ();
   regfile_multiport_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if1 ();

   assign if0.run          = run;
   assign if0.wr_en        = wr;
   assign if0.wr_addr      = wa[1:0];
   assign if0.wr_data      = wd;
   assign if0.rd_addr_a    = ra[1:0];
   assign if0.rd_addr_b    = rb[1:0];
   assign if0.clear        = clr;
   assign if0.snap_save    = sav;
   assign if0.snap_restore = rest;

   assign if1.run          = run;
   assign if1.wr_en        = wr;
   assign if1.wr_addr      = wa;
   assign if1.wr_data      = wd;
   assign if1.rd_addr_a    = ra;
   assign if1.rd_addr_b    = rb;
   assign if1.clear        = clr;
   assign if1.snap_save    = sav;
   assign if1.snap_restore = rest;

   regfile_multiport #(
      .DATA_WIDTH(8), .NUM_REGS(4), .BYPASS(1'b1)
   ) dut0 (
      .clock(clock), .reset_n(rst_n), .bus(if0.slave)
   );

   regfile_multiport #(
      .DATA_WIDTH(8), .NUM_REGS(5), .BYPASS(1'b0)
   ) dut1 (
      .clock(clock), .reset_n(rst_n), .bus(if1.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: dut k has nregs(k) registers; dut0 sees addr mod 4.
   int live [2][8];
   int shad [2][8];
   int m_a [2];
   int m_b [2];
   int m_v [2];
   int m_sv [2];

   function automatic int nregs(int k);
      return (k == 0) ? 4 : 5;
   endfunction

   function automatic int amap(int k, int a);
      return (k == 0) ? (a % 4) : a;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) begin
            live[k][i] = 0;
            shad[k][i] = 0;
         end
         m_a[k] = 0; m_b[k] = 0; m_v[k] = 0; m_sv[k] = 0;
      end
   endtask

   task automatic model_step();
      int pre [8];
      int n, w, x, y;
      for (int k = 0; k < 2; k++) begin
         n = nregs(k);
         w = amap(k, int'(wa));
         x = amap(k, int'(ra));
         y = amap(k, int'(rb));
         if (!run) begin
            m_v[k] = 0;
         end else begin
            for (int i = 0; i < 8; i++) pre[i] = live[k][i];
            if (clr) begin
               for (int i = 0; i < n; i++) live[k][i] = 0;
            end else if (rest) begin
               for (int i = 0; i < n; i++) live[k][i] = shad[k][i];
            end else if (wr && w < n) begin
               live[k][w] = int'(wd);
            end
            if (sav) begin
               for (int i = 0; i < n; i++) shad[k][i] = pre[i];
               m_sv[k] = 1;
            end
            if (k == 0) begin
               m_a[k] = (x < n) ? live[k][x] : 0;
               m_b[k] = (y < n) ? live[k][y] : 0;
            end else begin
               m_a[k] = (x < n) ? pre[x] : 0;
               m_b[k] = (y < n) ? pre[y] : 0;
            end
            m_v[k] = 1;
         end
      end
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("m0_a",  32'(if0.rd_data_a),  m_a[0]);
      chk("m0_b",  32'(if0.rd_data_b),  m_b[0]);
      chk("m0_v",  32'(if0.rd_valid),   m_v[0]);
      chk("m0_sv", 32'(if0.snap_valid), m_sv[0]);
      chk("m1_a",  32'(if1.rd_data_a),  m_a[1]);
      chk("m1_b",  32'(if1.rd_data_b),  m_b[1]);
      chk("m1_v",  32'(if1.rd_valid),   m_v[1]);
      chk("m1_sv", 32'(if1.snap_valid), m_sv[1]);
   endtask

   task automatic cyc();
      @(posedge clock);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic idle();
      run = 1'b1; wr = 1'b0; clr = 1'b0; sav = 1'b0; rest = 1'b0;
      wa = '0; wd = '0; ra = '0; rb = '0;
   endtask

   typedef struct {
      bit run; bit wr; int wa; int wd; int ra; int rb;
      bit clr; bit sav; bit rest;
      int ea0; int eb0; int ea1; int eb1; bit ev; bit esv;
   } vec_t;

   function automatic vec_t mk(
      bit r, bit w, int a, int d, int x, int y,
      bit c, bit s, bit t,
      int a0, int b0, int a1, int b1, bit v, bit sv
   );
      vec_t e;
      e.run = r; e.wr = w; e.wa = a; e.wd = d; e.ra = x; e.rb = y;
      e.clr = c; e.sav = s; e.rest = t;
      e.ea0 = a0; e.eb0 = b0; e.ea1 = a1; e.eb1 = b1;
      e.ev = v; e.esv = sv;
      return e;
   endfunction

   vec_t tbl [$];

   initial begin
      vectors = 0;
      miscompares = 0;
      // run wr wa wd ra rb clr sav rest | a0 b0 a1 b1 v sv
      tbl.push_back(mk(1,1,0,'h11,0,0,0,0,0, 'h11,'h11,0,0,1,0));
      tbl.push_back(mk(1,1,1,'h22,0,1,0,0,0, 'h11,'h22,'h11,0,1,0));
      tbl.push_back(mk(1,1,2,'h33,2,3,0,0,0, 'h33,0,0,0,1,0));
      tbl.push_back(mk(1,1,3,'h44,2,3,0,0,0, 'h33,'h44,'h33,0,1,0));
      tbl.push_back(mk(1,0,0,0,2,3,0,0,0, 'h33,'h44,'h33,'h44,1,0));
      tbl.push_back(mk(1,1,1,'h5A,1,1,0,0,0, 'h5A,'h5A,'h22,'h22,1,0));
      tbl.push_back(mk(1,1,1,'h22,1,0,0,0,0, 'h22,'h11,'h5A,'h11,1,0));
      tbl.push_back(mk(0,1,0,'hFF,0,0,1,1,0, 'h22,'h11,'h5A,'h11,0,0));
      tbl.push_back(mk(1,0,0,0,0,1,0,0,0, 'h11,'h22,'h11,'h22,1,0));
      tbl.push_back(mk(1,0,0,0,0,1,0,1,0, 'h11,'h22,'h11,'h22,1,1));
      tbl.push_back(mk(1,1,0,'hAA,0,1,0,0,0, 'hAA,'h22,'h11,'h22,1,1));
      tbl.push_back(mk(1,1,1,'hAA,2,1,0,0,0, 'h33,'hAA,'h33,'h22,1,1));
      tbl.push_back(mk(1,1,2,'hAA,2,3,0,0,0, 'hAA,'h44,'h33,'h44,1,1));
      tbl.push_back(mk(1,1,3,'hAA,3,0,0,0,0, 'hAA,'hAA,'h44,'hAA,1,1));
      tbl.push_back(mk(1,0,0,0,0,3,0,0,1, 'h11,'h44,'hAA,'hAA,1,1));
      tbl.push_back(mk(1,0,0,0,1,2,0,0,0, 'h22,'h33,'h22,'h33,1,1));
      tbl.push_back(mk(1,1,3,'hAA,3,3,0,0,0, 'hAA,'hAA,'h44,'h44,1,1));
      tbl.push_back(mk(1,1,0,'h77,0,3,0,1,1, 'h11,'h44,'h11,'hAA,1,1));
      tbl.push_back(mk(1,0,0,0,3,0,0,0,1, 'hAA,'h11,'h44,'h11,1,1));
      tbl.push_back(mk(1,1,2,'h99,2,3,1,0,0, 0,0,'h33,'hAA,1,1));
      tbl.push_back(mk(1,0,0,0,0,2,0,0,0, 0,0,0,0,1,1));
      tbl.push_back(mk(1,0,0,0,2,3,0,0,1, 'h33,'hAA,0,0,1,1));
      tbl.push_back(mk(1,0,0,0,0,3,0,0,0, 'h11,'hAA,'h11,'hAA,1,1));

      idle();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_a0",  32'(if0.rd_data_a), 0);
      chk("rst_b1",  32'(if1.rd_data_b), 0);
      chk("rst_v0",  32'(if0.rd_valid), 0);
      chk("rst_sv1", 32'(if1.snap_valid), 0);
      rst_n = 1'b1;

      foreach (tbl[j]) begin
         run = tbl[j].run; wr = tbl[j].wr;
         wa = 3'(tbl[j].wa); wd = 8'(tbl[j].wd);
         ra = 3'(tbl[j].ra); rb = 3'(tbl[j].rb);
         clr = tbl[j].clr; sav = tbl[j].sav; rest = tbl[j].rest;
         cyc();
         chk($sformatf("t%0d_a0", j), 32'(if0.rd_data_a), tbl[j].ea0);
         chk($sformatf("t%0d_b0", j), 32'(if0.rd_data_b), tbl[j].eb0);
         chk($sformatf("t%0d_a1", j), 32'(if1.rd_data_a), tbl[j].ea1);
         chk($sformatf("t%0d_b1", j), 32'(if1.rd_data_b), tbl[j].eb1);
         chk($sformatf("t%0d_v0", j), 32'(if0.rd_valid), 32'(tbl[j].ev));
         chk($sformatf("t%0d_v1", j), 32'(if1.rd_valid), 32'(tbl[j].ev));
         chk($sformatf("t%0d_s0", j), 32'(if0.snap_valid), 32'(tbl[j].esv));
         chk($sformatf("t%0d_s1", j), 32'(if1.snap_valid), 32'(tbl[j].esv));
      end

      // Out-of-range access on the 5-register file.
      idle();
      wr = 1'b1; wa = 3'd6; wd = 8'hEE; ra = 3'd7; rb = 3'd4;
      cyc();
      chk("oor_rd7", 32'(if1.rd_data_a), 0);
      chk_model();
      idle();
      wr = 1'b1; wa = 3'd4; wd = 8'h5C; ra = 3'd4; rb = 3'd6;
      cyc();
      chk_model();
      idle();
      ra = 3'd4; rb = 3'd6;
      cyc();
      chk("r4_rd", 32'(if1.rd_data_a), 'h5C);
      chk("oor_rd6", 32'(if1.rd_data_b), 0);
      chk_model();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         run  = ($urandom % 8) != 0;
         wr   = 1'($urandom % 2);
         wa   = 3'($urandom % 8);
         wd   = 8'($urandom % 256);
         ra   = 3'($urandom % 8);
         rb   = 3'($urandom % 8);
         clr  = ($urandom % 16) == 0;
         sav  = ($urandom % 8) == 0;
         rest = ($urandom % 8) == 0;
         cyc();
         chk_model();
      end

      // Async reset in the middle of a burst, away from any edge.
      idle();
      sav = 1'b1;
      wr = 1'b1; wa = 3'd1; wd = 8'h3C; ra = 3'd1; rb = 3'd1;
      cyc();
      chk_model();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_a0",  32'(if0.rd_data_a), 0);
      chk("arst_b1",  32'(if1.rd_data_b), 0);
      chk("arst_v0",  32'(if0.rd_valid), 0);
      chk("arst_sv0", 32'(if0.snap_valid), 0);
      chk("arst_sv1", 32'(if1.snap_valid), 0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      idle();
      wr = 1'b1; wa = 3'd0; wd = 8'h05; ra = 3'd0; rb = 3'd1;
      cyc();
      chk_model();
      idle();
      rest = 1'b1; ra = 3'd0; rb = 3'd1;
      cyc();
      chk("rst_shd0", 32'(if0.rd_data_a), 0);
      chk("rst_shd1", 32'(if1.rd_data_a), 'h05);
      chk_model();
      idle();
      ra = 3'd0; rb = 3'd1;
      cyc();
      chk("rst_shd1b", 32'(if1.rd_data_a), 0);
      chk_model();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
